// File: rtl/vector_pkg.sv
// ----------------------------------------------------------------------------
// vector_pkg
//  Shared constants and types for the vector nibble packing/unpacking path.
//  NIB_W    : width of one nibble
//  NUM_NIB  : nibbles per packed word
//  ONEHOT_W : width of the one-hot decode; legal nibble values are 0..ONEHOT_W-1
//  WORD_W   : packed word width
//  IDX_W    : width of the nibble index
// ----------------------------------------------------------------------------
package vector_pkg;

    localparam int unsigned NIB_W    = 4;
    localparam int unsigned NUM_NIB  = 3;
    localparam int unsigned ONEHOT_W = 13;
    localparam int unsigned WORD_W   = NIB_W * NUM_NIB;
    localparam int unsigned IDX_W    = 2;

    // Index of the final nibble of a word.
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NIB - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

endpackage

// File: rtl/vector_onehot_dec.sv
// ----------------------------------------------------------------------------
// vector_onehot_dec
//  Combinational nibble -> one-hot decoder, shared by one-hot consumers.
//  nib_i    in   NIB_W     nibble value
//  onehot_o out  ONEHOT_W  1<<nib_i when nib_i < ONEHOT_W, else all zero
//  err_o    out  1         nib_i is outside the one-hot range
// ----------------------------------------------------------------------------
module vector_onehot_dec
    import vector_pkg::*;
(
    input  logic [NIB_W-1:0]    nib_i,
    output logic [ONEHOT_W-1:0] onehot_o,
    output logic                err_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < ONEHOT_W; i++) begin
            onehot_o[i] = (nib_i == NIB_W'(i));
        end
        err_o = (32'(nib_i) >= ONEHOT_W);
    end

endmodule

// File: rtl/vector_nibble_serializer.sv
// ----------------------------------------------------------------------------
// vector_nibble_serializer
//  Takes one packed word {nib2,nib1,nib0} per handshake and emits its nibbles
//  one per beat (nib0 first) on a valid/ready stream, each with its one-hot
//  decode and an out-of-range error flag.
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous active-high reset
//  word_valid_in  in   1   packed word available
//  word_ready_out out  1   word can be taken this cycle
//  word_in        in   12  packed word, [3:0]=nib0 .. [11:8]=nib2
//  nib_valid_out  out  1   beat valid
//  nib_ready_in   in   1   consumer accepts beat
//  nib_out        out  4   nibble value
//  nib_idx_out    out  2   nibble index 0..2
//  nib_last_out   out  1   final nibble of the word
//  nib_onehot_out out  13  one-hot decode of nib_out
//  nib_err_out    out  1   nib_out outside the one-hot range
//  busy_out       out  1   word held, beats outstanding
// ----------------------------------------------------------------------------
module vector_nibble_serializer
    import vector_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 word_valid_in,
    output logic                 word_ready_out,
    input  logic [WORD_W-1:0]    word_in,
    output logic                 nib_valid_out,
    input  logic                 nib_ready_in,
    output logic [NIB_W-1:0]     nib_out,
    output logic [IDX_W-1:0]     nib_idx_out,
    output logic                 nib_last_out,
    output logic [ONEHOT_W-1:0]  nib_onehot_out,
    output logic                 nib_err_out,
    output logic                 busy_out
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q,  word_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;

    logic                sending;
    logic                at_last;
    logic                beat;
    logic                accept;
    logic [NIB_W-1:0]    cur_nib;
    logic [ONEHOT_W-1:0] dec_onehot;
    logic                dec_err;

    assign sending = (state_q == ST_SEND);
    assign at_last = (idx_q == IDX_LAST);
    assign beat    = sending & nib_ready_in;

    // Ready is forced low while rst is asserted so that every output reads 0
    // during reset, yet rises in the very first cycle after release.
    assign word_ready_out = ~rst & (~sending | (at_last & nib_ready_in));
    assign accept         = word_valid_in & word_ready_out;

    always_comb begin
        cur_nib = '0;
        for (int unsigned i = 0; i < NUM_NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = word_q[i*NIB_W +: NIB_W];
            end
        end
    end

    vector_onehot_dec u_dec (
        .nib_i    (cur_nib),
        .onehot_o (dec_onehot),
        .err_o    (dec_err)
    );

    // State, word and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat && at_last) begin
                    state_d = accept ? ST_SEND : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            word_d = word_in;
            idx_d  = '0;
        end else if (beat && !at_last) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Beat outputs are zeroed outside SEND so the idle decode of the cleared
    // word (value 0 -> bit 0) never leaks onto the stream.
    always_comb begin
        nib_valid_out  = sending;
        busy_out       = sending;
        nib_out        = '0;
        nib_idx_out    = '0;
        nib_last_out   = 1'b0;
        nib_onehot_out = '0;
        nib_err_out    = 1'b0;
        if (sending) begin
            nib_out        = cur_nib;
            nib_idx_out    = idx_q;
            nib_last_out   = at_last;
            nib_onehot_out = dec_onehot;
            nib_err_out    = dec_err;
        end
    end

endmodule

// File: tb/tb_vector_nibble_serializer.sv
module tb_vector_nibble_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        word_valid_in = 1'b0;
    logic        word_ready_out;
    logic [11:0] word_in = '0;
    logic        nib_valid_out;
    logic        nib_ready_in = 1'b0;
    logic [3:0]  nib_out;
    logic [1:0]  nib_idx_out;
    logic        nib_last_out;
    logic [12:0] nib_onehot_out;
    logic        nib_err_out;
    logic        busy_out;

    vector_nibble_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .word_valid_in  (word_valid_in),
        .word_ready_out (word_ready_out),
        .word_in        (word_in),
        .nib_valid_out  (nib_valid_out),
        .nib_ready_in   (nib_ready_in),
        .nib_out        (nib_out),
        .nib_idx_out    (nib_idx_out),
        .nib_last_out   (nib_last_out),
        .nib_onehot_out (nib_onehot_out),
        .nib_err_out    (nib_err_out),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit model_live = 0;
    bit rand_mode  = 0;

    typedef struct { logic [3:0] nib; logic [1:0] idx; } beat_t;
    typedef struct { logic [3:0] nib; logic [1:0] idx; logic last;
                     logic [12:0] oh; logic err; int cyc; } obs_t;

    beat_t exp_q[$];   // nibbles still owed to the consumer, in order
    obs_t  obs_q[$];   // beats actually delivered by the DUT

    function automatic logic [12:0] ref_onehot(input logic [3:0] v);
        return (v < 4'd13) ? (13'd1 << v) : 13'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a word accepted pushes its three nibbles; a fired beat pops one.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            model_live = 1;
        end else if (model_live) begin
            bit rdy;
            rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && nib_ready_in);
            if (exp_q.size() > 0 && nib_ready_in) void'(exp_q.pop_front());
            if (word_valid_in && rdy) begin
                for (int i = 0; i < 3; i++) begin
                    beat_t b;
                    b.nib = word_in[i*4 +: 4];
                    b.idx = 2'(i);
                    exp_q.push_back(b);
                end
            end
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (model_live) begin
            bit v;
            bit rdy;
            v   = (exp_q.size() > 0);
            rdy = !rst && ((exp_q.size() == 0) || (exp_q.size() == 1 && nib_ready_in));
            chk("valid", 32'(nib_valid_out), 32'(v));
            chk("busy", 32'(busy_out), 32'(v));
            chk("word_ready", 32'(word_ready_out), 32'(rdy));
            if (v) begin
                chk("nib", 32'(nib_out), 32'(exp_q[0].nib));
                chk("idx", 32'(nib_idx_out), 32'(exp_q[0].idx));
                chk("last", 32'(nib_last_out), 32'(exp_q[0].idx == 2'd2));
                chk("onehot", 32'(nib_onehot_out), 32'(ref_onehot(exp_q[0].nib)));
                chk("err", 32'(nib_err_out), 32'(exp_q[0].nib >= 4'd13));
            end else begin
                chk("idle_outputs",
                    {13'd0, nib_out, nib_idx_out, nib_last_out, nib_onehot_out, nib_err_out}, 32'd0);
            end
            if (!rst && nib_valid_out && nib_ready_in) begin
                obs_t o;
                o.nib = nib_out; o.idx = nib_idx_out; o.last = nib_last_out;
                o.oh = nib_onehot_out; o.err = nib_err_out; o.cyc = cyc;
                obs_q.push_back(o);
            end
        end
    end

    // Random consumer backpressure.
    always @(posedge clk) begin
        #1;
        if (rand_mode) nib_ready_in = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until taken; valid stays up afterwards.
    task automatic send_word(input logic [11:0] w, output int acc_cyc);
        bit done;
        done = 0;
        acc_cyc = -1;
        word_in = w;
        word_valid_in = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            #1;
            done = word_ready_out;
            tick();
        end
        if (done) acc_cyc = cyc;
        else chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        int acc;
        int nwords;
        logic [3:0] seq [6];

        // 1: reset with a word pending
        rst = 1'b1; word_valid_in = 1'b1; word_in = 12'hABC;
        repeat (3) begin
            tick();
            chk("rst_valid", 32'(nib_valid_out), 32'd0);
            chk("rst_ready", 32'(word_ready_out), 32'd0);
        end
        rst = 1'b0; word_valid_in = 1'b0;
        #1;
        chk("ready_after_reset", 32'(word_ready_out), 32'd1);
        repeat (3) tick();
        chk("no_prereset_beats", 32'(obs_q.size()), 32'd0);

        // 2: single word
        obs_q.delete();
        nib_ready_in = 1'b1;
        send_word(12'h3A5, acc);
        word_valid_in = 1'b0;
        drain();
        chk("single_count", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk("single_latency", 32'(obs_q[0].cyc), 32'(acc));
            chk("single_b0", {obs_q[0].nib, 2'b0, obs_q[0].idx, 3'b0, obs_q[0].last, obs_q[0].oh},
                {4'h5, 2'b0, 2'd0, 3'b0, 1'b0, 13'h0020});
            chk("single_b1", {obs_q[1].nib, 2'b0, obs_q[1].idx, 3'b0, obs_q[1].last, obs_q[1].oh},
                {4'hA, 2'b0, 2'd1, 3'b0, 1'b0, 13'h0400});
            chk("single_b2", {obs_q[2].nib, 2'b0, obs_q[2].idx, 3'b0, obs_q[2].last, obs_q[2].oh},
                {4'h3, 2'b0, 2'd2, 3'b0, 1'b1, 13'h0008});
        end

        // 3: back-to-back words
        obs_q.delete();
        send_word(12'h210, acc);
        send_word(12'h543, acc);
        word_valid_in = 1'b0;
        drain();
        chk("b2b_count", 32'(obs_q.size()), 32'd6);
        if (obs_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("b2b_nib", 32'(obs_q[i].nib), 32'(i));
                if (i > 0) chk("b2b_no_bubble", 32'(obs_q[i].cyc), 32'(obs_q[i-1].cyc + 1));
            end
        end

        // 4: backpressure
        obs_q.delete();
        nib_ready_in = 1'b0;
        send_word(12'h987, acc);
        word_valid_in = 1'b0;
        seq[0] = 0; seq[1] = 0; seq[2] = 1; seq[3] = 0; seq[4] = 1; seq[5] = 1;
        for (int i = 0; i < 6; i++) begin
            nib_ready_in = seq[i][0];
            tick();
        end
        nib_ready_in = 1'b1;
        drain();
        chk("bp_count", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk("bp_nibs", {20'd0, obs_q[0].nib, obs_q[1].nib, obs_q[2].nib}, 32'h789);
            chk("bp_gap", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd2);
        end

        // 5: out-of-range nibble values
        obs_q.delete();
        send_word(12'hFDC, acc);
        word_valid_in = 1'b0;
        drain();
        chk("err_count", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk("err_b0", {obs_q[0].nib, obs_q[0].err, obs_q[0].oh}, {4'hC, 1'b0, 13'h1000});
            chk("err_b1", {obs_q[1].nib, obs_q[1].err, obs_q[1].oh}, {4'hD, 1'b1, 13'h0000});
            chk("err_b2", {obs_q[2].nib, obs_q[2].err, obs_q[2].oh}, {4'hF, 1'b1, 13'h0000});
        end

        // 6: reset after the first beat of a word
        obs_q.delete();
        send_word(12'h456, acc);
        word_valid_in = 1'b0;
        tick();                       // nib0 beat fires at this edge
        rst = 1'b1; nib_ready_in = 1'b0;
        tick();
        rst = 1'b0; nib_ready_in = 1'b1;
        #1;
        chk("midrst_valid", 32'(nib_valid_out), 32'd0);
        repeat (3) tick();
        chk("midrst_count", 32'(obs_q.size()), 32'd1);
        send_word(12'h321, acc);
        word_valid_in = 1'b0;
        drain();
        chk("midrst_total", 32'(obs_q.size()), 32'd4);
        if (obs_q.size() == 4) begin
            chk("midrst_first", {obs_q[0].nib, obs_q[0].idx}, {4'h6, 2'd0});
            chk("midrst_next", {obs_q[1].nib, obs_q[1].idx}, {4'h1, 2'd0});
        end

        // Random traffic with random gaps and backpressure
        obs_q.delete();
        rand_mode = 1;
        nwords = 150;
        for (int n = 0; n < nwords; n++) begin
            send_word(12'($urandom), acc);
            if ($urandom_range(0, 2) == 0) begin
                word_valid_in = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
            end
        end
        word_valid_in = 1'b0;
        rand_mode = 0;
        nib_ready_in = 1'b1;
        drain();
        chk("rand_beat_count", 32'(obs_q.size()), 32'(3 * nwords));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
